hilo_muldiv: RTL and testbench

//  Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU. It sits in EX and feeds the HI/LO write port of the register file.

---
 rtl/hilo_muldiv_pkg.sv | 25 ++
 rtl/hilo_muldiv_if.sv | 34 +++
 rtl/hilo_muldiv_iter_core.sv | 62 ++++++
 rtl/hilo_muldiv.sv | 168 ++++++++++++++++
 tb/tb_hilo_muldiv.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_pkg
// Description : Opcodes, FSM state encoding and widths shared by the
//               HI/LO multiply/divide unit and its testbench.
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_muldiv_pkg;

  localparam int c_DATA_W = 32;
  localparam int c_OP_W   = 2;

  localparam logic [1:0] c_MD_MULT  = 2'b00;
  localparam logic [1:0] c_MD_MULTU = 2'b01;
  localparam logic [1:0] c_MD_DIV   = 2'b10;
  localparam logic [1:0] c_MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_if
// Description : EX-stage request / HI-LO write-port bundle of the muldiv unit.
//               master = pipeline side, slave = muldiv unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface hilo_muldiv_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 2
);
  logic              start;
  logic [OP_W-1:0]   md_op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              cancel;
  logic              stall;
  logic              busy;
  logic              hi_we;
  logic [DATA_W-1:0] hi_wdata;
  logic              lo_we;
  logic [DATA_W-1:0] lo_wdata;

  modport master (
    output start, md_op, src_a, src_b, cancel,
    input  stall, busy, hi_we, hi_wdata, lo_we, lo_wdata
  );

  modport slave (
    input  start, md_op, src_a, src_b, cancel,
    output stall, busy, hi_we, hi_wdata, lo_we, lo_wdata
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_iter_core
// Description : 64-bit shift register plus 33-bit add/sub datapath. Performs
//               one shift-add multiply step or one restoring divide step per
//               step pulse. acc_nxt exposes the value the next step will hold
//               so the caller can capture the final result on the last edge.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [DATA_W-1:0]     opa,      // multiplier / dividend magnitude
  input  logic [DATA_W-1:0]     opb,      // multiplicand / divisor magnitude
  output logic [2*DATA_W-1:0]   acc_nxt
);

  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_rem_sh;
  logic                w_ge;
  logic [DATA_W-1:0]   w_diff;

  // Single-step datapath. Multiply: add multiplicand into the upper half when
  // the LSB is set, then shift the 33-bit sum back in. Divide: shift the
  // partial remainder left and subtract the divisor if it fits. When the
  // subtract succeeds the true difference is below the divisor, so 32 bits
  // of it are enough.
  always_comb begin
    w_sum    = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_rem_sh = r_acc[2*DATA_W-1:DATA_W-1];
    w_ge     = (w_rem_sh >= {1'b0, r_b});
    w_diff   = w_rem_sh[DATA_W-1:0] - r_b;
    if (is_div) begin
      acc_nxt = w_ge ? {w_diff, r_acc[DATA_W-2:0], 1'b1}
                     : {r_acc[2*DATA_W-2:0], 1'b0};
    end else begin
      acc_nxt = {w_sum, r_acc[DATA_W-1:1]};
    end
  end

  // Accumulator and second-operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_b   <= '0;
    end else if (load) begin
      r_acc <= {{DATA_W{1'b0}}, opa};
      r_b   <= opb;
    end else if (step) begin
      r_acc <= acc_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv
// Description : Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO write
//               port. Sign pre-processing, iteration FSM, result sign fix-up
//               and the registered one-cycle HI/LO write pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  hilo_muldiv_if.slave   md
);

  localparam int             CNT_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [OP_W-1:0]     r_op;
  logic                r_neg_res;
  logic                r_neg_rem;
  logic                r_dbz;
  logic [DATA_W-1:0]   r_src_a;
  logic                r_busy;
  logic                r_we;
  logic [DATA_W-1:0]   r_hi_wdata;
  logic [DATA_W-1:0]   r_lo_wdata;

  logic                w_load;
  logic                w_step;
  logic                w_signed_op;
  logic                w_neg_a;
  logic                w_neg_b;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic                w_is_div;
  logic [2*DATA_W-1:0] w_acc_nxt;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_hi_res;
  logic [DATA_W-1:0]   w_lo_res;

  // Operand magnitudes; -0x8000_0000 wraps to 2^31, which is the correct
  // unsigned magnitude.
  assign w_signed_op = (md.md_op == c_MD_MULT) || (md.md_op == c_MD_DIV);
  assign w_neg_a     = w_signed_op & md.src_a[DATA_W-1];
  assign w_neg_b     = w_signed_op & md.src_b[DATA_W-1];
  assign w_mag_a     = w_neg_a ? -md.src_a : md.src_a;
  assign w_mag_b     = w_neg_b ? -md.src_b : md.src_b;
  assign w_is_div    = (r_op == c_MD_DIV) || (r_op == c_MD_DIVU);

  hilo_muldiv_iter_core #(.DATA_W(DATA_W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .step    (w_step),
    .is_div  (w_is_div),
    .opa     (w_mag_a),
    .opb     (w_mag_b),
    .acc_nxt (w_acc_nxt)
  );

  // Next-state logic; cancel in CALC aborts, DONE always commits.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (md.start && !md.cancel) begin
          w_state_nxt = S_CALC;
          w_load      = 1'b1;
        end
      end
      S_CALC: begin
        if (md.cancel) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == c_LAST) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pipeline hold; forced low while reset is asserted.
  assign md.stall = rst_n & (((r_state == S_IDLE) & md.start & ~md.cancel) |
                             (r_state == S_CALC));

  // Final result from the value the last step produces. Divide-by-zero
  // bypasses the sign fix and reports the raw dividend.
  always_comb begin
    w_prod   = r_neg_res ? -w_acc_nxt : w_acc_nxt;
    w_quo    = w_acc_nxt[DATA_W-1:0];
    w_rem    = w_acc_nxt[2*DATA_W-1:DATA_W];
    w_hi_res = w_prod[2*DATA_W-1:DATA_W];
    w_lo_res = w_prod[DATA_W-1:0];
    if (w_is_div) begin
      if (r_dbz) begin
        w_lo_res = '1;
        w_hi_res = r_src_a;
      end else begin
        w_lo_res = r_neg_res ? -w_quo : w_quo;
        w_hi_res = r_neg_rem ? -w_rem : w_rem;
      end
    end
  end

  // State, iteration counter and the operation context latched at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dbz     <= 1'b0;
      r_src_a   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_cnt     <= '0;
        r_op      <= md.md_op;
        r_neg_res <= w_neg_a ^ w_neg_b;
        r_neg_rem <= w_neg_a;
        r_dbz     <= (md.src_b == '0);
        r_src_a   <= md.src_a;
      end else if (w_step) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Registered busy flag, write pulse and HI/LO data (data held between ops).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_we       <= 1'b0;
      r_hi_wdata <= '0;
      r_lo_wdata <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_we   <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_DONE) begin
        r_hi_wdata <= w_hi_res;
        r_lo_wdata <= w_lo_res;
      end
    end
  end

  assign md.busy     = r_busy;
  assign md.hi_we    = r_we;
  assign md.lo_we    = r_we;
  assign md.hi_wdata = r_hi_wdata;
  assign md.lo_wdata = r_lo_wdata;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_muldiv
// Description : Directed self-checking bench for hilo_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hilo_muldiv_if #(.DATA_W(32), .OP_W(2)) md_if ();

  hilo_muldiv #(.DATA_W(32), .OP_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md_if)
  );

  // Presents one op at a negedge, holds start while stalled, and checks
  // stall length, pulse count, pulse alignment and HI/LO data.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int          stall_cyc;
    int          we_cyc;
    logic        aligned;
    logic [31:0] got_hi;
    logic [31:0] got_lo;
    stall_cyc = 0; we_cyc = 0; aligned = 1'b1; got_hi = '0; got_lo = '0;
    md_if.start = 1'b1; md_if.md_op = op; md_if.src_a = a; md_if.src_b = b;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (md_if.stall) stall_cyc++;
      if (md_if.hi_we) begin
        we_cyc++; got_hi = md_if.hi_wdata; got_lo = md_if.lo_wdata;
      end
      if (md_if.hi_we !== md_if.lo_we) aligned = 1'b0;
      if (!md_if.stall) md_if.start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (stall_cyc !== 33) begin
      errors++; $display("FAIL %s stall_cycles: got %0d expected 33", name, stall_cyc);
    end
    checks++;
    if (we_cyc !== 1 || aligned !== 1'b1) begin
      errors++; $display("FAIL %s write_pulses: got %0d aligned=%0b expected 1 aligned=1", name, we_cyc, aligned);
    end
    checks++;
    if (got_hi !== exp_hi) begin
      errors++; $display("FAIL %s hi: got %h expected %h", name, got_hi, exp_hi);
    end
    checks++;
    if (got_lo !== exp_lo) begin
      errors++; $display("FAIL %s lo: got %h expected %h", name, got_lo, exp_lo);
    end
    checks++;
    if (md_if.busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_after: got %b expected 0", name, md_if.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    md_if.start = 1'b0; md_if.cancel = 1'b0; md_if.md_op = c_MD_MULT;
    md_if.src_a = '0; md_if.src_b = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({md_if.busy, md_if.hi_we, md_if.lo_we, md_if.stall} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got busy=%b hi_we=%b lo_we=%b stall=%b expected 0000",
                         md_if.busy, md_if.hi_we, md_if.lo_we, md_if.stall);
    end
    checks++;
    if (md_if.hi_wdata !== 32'h0 || md_if.lo_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: got hi=%h lo=%h expected 0 0", md_if.hi_wdata, md_if.lo_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    run_op("multu_max", c_MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  c_MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_min",  c_MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
  endtask

  task automatic test_div();
    run_op("divu_7_2",   c_MD_DIVU, 32'd7,         32'd2,         32'd1,         32'd3);
    run_op("div_m7_2",   c_MD_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2",   c_MD_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    run_op("div_min_m1", c_MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
  endtask

  task automatic test_div_zero();
    run_op("divu_5_0",  c_MD_DIVU, 32'd5,         32'd0, 32'd5,         32'hFFFF_FFFF);
    run_op("div_m5_0",  c_MD_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
  endtask

  task automatic test_cancel();
    logic seen_we;
    seen_we = 1'b0;
    md_if.start = 1'b1; md_if.md_op = c_MD_DIVU; md_if.src_a = 32'd1000; md_if.src_b = 32'd3;
    for (int i = 0; i < 11; i++) begin
      #1;
      if (md_if.hi_we || md_if.lo_we) seen_we = 1'b1;
      @(negedge clk);
    end
    // now in CALC with cnt == 10
    checks++;
    if (md_if.busy !== 1'b1) begin
      errors++; $display("FAIL cancel_busy_before: got %b expected 1", md_if.busy);
    end
    md_if.cancel = 1'b1; md_if.start = 1'b0;
    @(negedge clk);
    md_if.cancel = 1'b0;
    #1;
    checks++;
    if (md_if.busy !== 1'b0 || md_if.stall !== 1'b0) begin
      errors++; $display("FAIL cancel_idle: got busy=%b stall=%b expected 0 0", md_if.busy, md_if.stall);
    end
    checks++;
    if (seen_we || md_if.hi_we || md_if.lo_we) begin
      errors++; $display("FAIL cancel_no_write: got pulse=%b expected 0", seen_we | md_if.hi_we | md_if.lo_we);
    end
    run_op("after_cancel", c_MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
  endtask

  task automatic test_async_reset();
    md_if.start = 1'b1; md_if.md_op = c_MD_MULTU;
    md_if.src_a = 32'h1234_5678; md_if.src_b = 32'h9ABC_DEF0;
    for (int i = 0; i < 21; i++) @(negedge clk);
    // CALC with cnt == 20; start deliberately left high
    checks++;
    if (md_if.busy !== 1'b1 || md_if.stall !== 1'b1) begin
      errors++; $display("FAIL areset_before: got busy=%b stall=%b expected 1 1", md_if.busy, md_if.stall);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({md_if.busy, md_if.hi_we, md_if.lo_we, md_if.stall} !== 4'b0000) begin
      errors++; $display("FAIL areset_flags: got busy=%b hi_we=%b lo_we=%b stall=%b expected 0000",
                         md_if.busy, md_if.hi_we, md_if.lo_we, md_if.stall);
    end
    checks++;
    if (md_if.hi_wdata !== 32'h0 || md_if.lo_wdata !== 32'h0) begin
      errors++; $display("FAIL areset_data: got hi=%h lo=%h expected 0 0", md_if.hi_wdata, md_if.lo_wdata);
    end
    md_if.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_reset", c_MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
  endtask

  // First op is MULTU 6*7; from cycle 5 the inputs switch to DIVU 100/7 with
  // start held. The switch must not disturb op 1, and op 2 may only start in
  // the IDLE cycle following DONE.
  task automatic test_back_to_back();
    int          n;
    int          idx0, idx1;
    logic        st0;
    logic [31:0] h0, l0, h1, l1;
    n = 0; idx0 = -1; idx1 = -1; st0 = 1'b1; h0 = '0; l0 = '0; h1 = '0; l1 = '0;
    md_if.start = 1'b1; md_if.md_op = c_MD_MULTU; md_if.src_a = 32'd6; md_if.src_b = 32'd7;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (md_if.hi_we) begin
        if (n == 0) begin
          idx0 = i; st0 = md_if.stall; h0 = md_if.hi_wdata; l0 = md_if.lo_wdata;
        end else if (n == 1) begin
          idx1 = i; h1 = md_if.hi_wdata; l1 = md_if.lo_wdata;
        end
        n++;
        if (n >= 2) md_if.start = 1'b0;
      end
      if (i == 5) begin
        md_if.md_op = c_MD_DIVU; md_if.src_a = 32'd100; md_if.src_b = 32'd7;
      end
      @(negedge clk);
    end
    checks++;
    if (n !== 2) begin
      errors++; $display("FAIL b2b_pulses: got %0d expected 2", n);
    end
    checks++;
    if (h0 !== 32'd0 || l0 !== 32'd42) begin
      errors++; $display("FAIL b2b_first: got hi=%h lo=%h expected 0 2a", h0, l0);
    end
    checks++;
    if (h1 !== 32'd2 || l1 !== 32'd14) begin
      errors++; $display("FAIL b2b_second: got hi=%h lo=%h expected 2 e", h1, l1);
    end
    checks++;
    if (idx0 !== 33 || idx1 !== 67) begin
      errors++; $display("FAIL b2b_timing: got pulses at %0d,%0d expected 33,67", idx0, idx1);
    end
    checks++;
    if (st0 !== 1'b0) begin
      errors++; $display("FAIL b2b_done_stall: got %b expected 0", st0);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_cancel();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
